// File: rtl/motor_cmd_ctrl.sv
// motor_cmd_ctrl: turns raw forward/reverse/stop push-buttons into the
// motor1/motor2 direction command pair, with per-button synchronisation,
// debouncing and an enforced dead-time between any change of direction.
// Optional build macro: RUN_TIMEOUT_EN adds a run-time limit that stops the
// motor after RUN_TIMEOUT cycles in FWD or REV.
module motor_cmd_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DEAD_CYCLES     = 2500000,
    parameter int CNT_W           = 22,
    parameter int RUN_TIMEOUT     = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_fwd,
    input  logic       btn_rev,
    input  logic       btn_stop,
    output logic       motor1,
    output logic       motor2,
    output logic       busy,
    output logic [1:0] state
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] FWD  = 2'b01;
    localparam logic [1:0] REV  = 2'b10;
    localparam logic [1:0] DEAD = 2'b11;
    // pending direction reuses the state codes; IDLE doubles as "none"
    localparam logic [1:0] PEND_NONE = IDLE;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEAD_CYCLES < 1 || RUN_TIMEOUT < 1 ||
        longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W) ||
        longint'(DEAD_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_params
        $error("motor_cmd_ctrl: invalid parameter set");
    end

    logic [2:0] btn_raw;
    logic [2:0] press;
    logic [1:0] prime_sr;
    logic       primed;

    assign btn_raw = {btn_stop, btn_rev, btn_fwd};
    assign primed  = prime_sr[1];

    // marks when the synchronisers hold real samples taken after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prime_sr <= '0;
        else     prime_sr <= {prime_sr[0], 1'b1};
    end

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic             s1, s2, lvl, lvl_d, armed;
        logic [CNT_W-1:0] cnt;

        // two-flop synchroniser for the raw button
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= btn_raw[i];
                s2 <= s1;
            end
        end

        // debounce: accept a new level after DEBOUNCE_CYCLES stable cycles;
        // a button only arms once it has been seen released, so one held
        // through reset produces no press until released and pressed again
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt   <= '0;
                lvl   <= 1'b0;
                lvl_d <= 1'b0;
                armed <= 1'b0;
            end else begin
                lvl_d <= lvl;
                if (primed && !s2 && !lvl) armed <= 1'b1;
                if (s2 != lvl) begin
                    if (cnt == DB_LAST) begin
                        lvl <= s2;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end

        assign press[i] = lvl & ~lvl_d & armed;
    end

    logic             fwd_p, rev_p, stop_p;
    logic [1:0]       state_q, state_n, pend_q, pend_n;
    logic [CNT_W-1:0] dead_cnt;
    logic             run_expired;

    assign fwd_p  = press[0];
    assign rev_p  = press[1];
    assign stop_p = press[2];

`ifdef RUN_TIMEOUT_EN
    localparam int RUN_W = $clog2(RUN_TIMEOUT + 1);
    logic [RUN_W-1:0] run_cnt;

    assign run_expired = (run_cnt == RUN_W'(RUN_TIMEOUT - 1));

    // run-time counter: cleared on entry to FWD/REV, counts while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run_cnt <= '0;
        else if (state_n == state_q && (state_q == FWD || state_q == REV))
            run_cnt <= run_cnt + RUN_W'(1);
        else
            run_cnt <= '0;
    end
`else
    assign run_expired = 1'b0;
`endif

    // next-state and pending-direction logic; stop outranks fwd/rev
    always_comb begin
        state_n = state_q;
        pend_n  = pend_q;
        case (state_q)
            IDLE: begin
                if (!stop_p) begin
                    if (fwd_p && !rev_p)      state_n = FWD;
                    else if (rev_p && !fwd_p) state_n = REV;
                end
            end
            FWD: begin
                if (stop_p) begin
                    state_n = DEAD;
                    pend_n  = PEND_NONE;
                end else if (rev_p) begin
                    state_n = DEAD;
                    pend_n  = REV;
                end else if (run_expired) begin
                    state_n = DEAD;
                    pend_n  = PEND_NONE;
                end
            end
            REV: begin
                if (stop_p) begin
                    state_n = DEAD;
                    pend_n  = PEND_NONE;
                end else if (fwd_p) begin
                    state_n = DEAD;
                    pend_n  = FWD;
                end else if (run_expired) begin
                    state_n = DEAD;
                    pend_n  = PEND_NONE;
                end
            end
            default: begin
                if (stop_p)               pend_n = PEND_NONE;
                else if (fwd_p && !rev_p) pend_n = FWD;
                else if (rev_p && !fwd_p) pend_n = REV;
                if (dead_cnt == DEAD_LAST) begin
                    state_n = pend_n;
                    pend_n  = PEND_NONE;
                end
            end
        endcase
    end

    // state, dead-time counter and outputs registered from next-state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pend_q   <= PEND_NONE;
            dead_cnt <= '0;
            motor1   <= 1'b0;
            motor2   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_n;
            pend_q   <= pend_n;
            dead_cnt <= (state_q == DEAD && state_n == DEAD) ? dead_cnt + CNT_W'(1) : '0;
            motor1   <= (state_n == FWD);
            motor2   <= (state_n == REV);
            busy     <= (state_n == DEAD);
        end
    end

    assign state = state_q;

endmodule

// File: doc/motor_cmd_ctrl.md
Name: motor_cmd_ctrl

Overview:
- Upstream command stage for the DC motor drivers and the status LED decoder.
- Converts three raw push-buttons (forward, reverse, stop) into the `motor1`/`motor2` direction command pair those blocks consume.
- Synchronises and debounces each button, then runs a direction FSM with an enforced dead-time.
- `motor1` and `motor2` are never high together.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level (≥2).
- DEAD_CYCLES, 2500000, cycles with both outputs low before any direction change or stop completes (≥1).
- CNT_W, 22, width of the debounce and dead-time counters; must hold max(DEBOUNCE_CYCLES, DEAD_CYCLES).
- RUN_TIMEOUT, 50000000, run-time limit in cycles; used only with RUN_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_fwd  input  1  raw forward button, asynchronous, active-high.
- btn_rev  input  1  raw reverse button, asynchronous, active-high.
- btn_stop  input  1  raw stop button, asynchronous, active-high.
- motor1  output  1  forward command, registered.
- motor2  output  1  reverse command, registered.
- busy  output  1  high while in DEAD, registered.
- state  output  2  FSM encoding: IDLE=00, FWD=01, REV=10, DEAD=11.

Behaviour:
- Reset: all outputs and internal registers go to 0 immediately, independent of clk.
  - state=IDLE; motor1=motor2=busy=0; debounced levels=0; pending=NONE.
  - Buttons held at reset release do not generate a press until released and pressed again.
- Sync: each button passes through a 2-flop synchroniser.
- Debounce, per button:
  - A counter runs while the synced level differs from the debounced level, and clears whenever they match.
  - The debounced level flips when the synced level has differed for DEBOUNCE_CYCLES consecutive cycles.
  - Press = one-cycle pulse on the debounced rising edge. Releases generate nothing.
- Latency: a clean press sampled at edge N changes motor1/motor2 at edge N+DEBOUNCE_CYCLES+2. Example: DEBOUNCE_CYCLES=4 → edge N+6.
- A glitch shorter than DEBOUNCE_CYCLES cycles never produces a press.
- FSM, priority stop > fwd/rev:
  - IDLE:
    - fwd press → FWD.
    - rev press → REV.
    - fwd and rev pressed in the same cycle → ignored, stay IDLE.
    - stop → stay IDLE.
  - FWD:
    - rev press → DEAD with pending=REV.
    - stop → DEAD with pending=NONE.
    - fwd press → ignored.
  - REV: symmetric to FWD (fwd press → DEAD with pending=FWD).
  - DEAD:
    - Dead counter loads 0 on entry; exit happens when the counter reaches DEAD_CYCLES-1, so DEAD lasts exactly DEAD_CYCLES cycles.
    - Exit goes to the pending direction, or to IDLE if pending=NONE.
    - A fwd or rev press during DEAD overwrites pending without restarting the counter.
    - A stop press during DEAD sets pending=NONE and wins over a simultaneous fwd/rev press.
    - A simultaneous fwd+rev press during DEAD is ignored.
- Every exit from FWD or REV passes through DEAD. Only IDLE→FWD and IDLE→REV are immediate.
- Outputs, registered from next-state: motor1=(state==FWD), motor2=(state==REV), busy=(state==DEAD).
- Reset asserted mid-operation, including mid-DEAD: immediate return to the reset values; counters cleared.

Optional Feature:
- Macro: RUN_TIMEOUT_EN.
- Defined:
  - A run counter clears on entry to FWD or REV and increments each cycle spent there.
  - When it reaches RUN_TIMEOUT-1, the FSM enters DEAD with pending=NONE, exactly as a stop press would.
  - A stop or reverse press in the same cycle takes precedence.
- Undefined: no run counter exists; FWD and REV persist indefinitely.

Test Plan (DEBOUNCE_CYCLES=4, DEAD_CYCLES=8, RUN_TIMEOUT=20):
- Reset asserted asynchronously mid-cycle while in FWD → motor1=0, motor2=0, busy=0, state=00 before the next clk edge.
- Hold btn_fwd high from edge 10, starting in IDLE → motor1=1 at edge 16, motor2=0, state=01. A 3-cycle btn_rev glitch → no change.
- In FWD, press btn_rev cleanly → motor1=0 and busy=1 for exactly 8 cycles, then motor2=1, state=10. motor1 and motor2 are never both 1.
- In REV, press btn_stop → DEAD for 8 cycles, then IDLE. A btn_fwd press landing mid-DEAD → exit to FWD instead of IDLE.
- btn_fwd and btn_rev press debounced in the same cycle in IDLE → stay IDLE. btn_stop and btn_rev debounced together in FWD → DEAD, then IDLE.
- With RUN_TIMEOUT_EN: enter FWD and press nothing → after 20 cycles busy=1 for 8 cycles, then state=00. Without the macro → FWD persists for 1000 cycles.
